// File: rtl/utim_pkg.sv
// Shared register map and channel configuration layout for the utim timer family.
package utim_pkg;

    localparam logic [5:0] ADDR_MCFG    = 6'h00;
    localparam logic [5:0] ADDR_MCNT_LO = 6'h01;
    localparam logic [5:0] ADDR_MCNT_HI = 6'h02;
    localparam logic [5:0] ADDR_PSC     = 6'h03;
    localparam logic [5:0] ADDR_IRQSTAT = 6'h04;
    localparam logic [5:0] ADDR_CH_BASE = 6'h08;
    localparam int         CH_STRIDE    = 4;

    // Word offsets inside one channel's four-register window
    typedef enum logic [1:0] {
        OFF_CMP_LO = 2'd0,
        OFF_CMP_HI = 2'd1,
        OFF_CFG    = 2'd2,
        OFF_PERIOD = 2'd3
    } ch_off_e;

    localparam int MCFG_ENA     = 0;
    localparam int CFG_ENA      = 0;
    localparam int CFG_IRQENA   = 1;
    localparam int CFG_MODE64   = 2;
    localparam int CFG_PERIODIC = 3;
    localparam int CFG_W        = 4;

    // First address of channel n's register window
    function automatic logic [5:0] ch_base(input int n);
        return ADDR_CH_BASE + 6'(CH_STRIDE * n);
    endfunction

endpackage

// File: rtl/utim_channel.sv
// One compare channel: CMP/PERIOD/CFG registers, CMP high-word write shadow,
// match detection and one-shot / periodic reload with a pending flag.
module utim_channel
    import utim_pkg::*;
#(
    parameter int P_CNT_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [P_CNT_W-1:0] count,
    input  logic               wr_en,
    input  logic               clr,
    input  logic [1:0]         off,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               pending,
    output logic               irq
);

    localparam int HI_W = P_CNT_W - 32;

    logic [P_CNT_W-1:0] cmp;
    logic [HI_W-1:0]    cmp_shadow;
    logic [31:0]        period;
    logic [CFG_W-1:0]   cfg;
    logic               lo_eq;
    logic               hi_eq;
    logic               match;
    ch_off_e            sel;

    assign sel   = ch_off_e'(off);
    assign lo_eq = (count[31:0] == cmp[31:0]);
    assign hi_eq = (count[P_CNT_W-1:32] == cmp[P_CNT_W-1:32]);
    // tick already carries the global enable; 32-bit mode ignores the high word
    assign match = tick & cfg[CFG_ENA] & lo_eq & (hi_eq | ~cfg[CFG_MODE64]);
    assign irq   = pending & cfg[CFG_IRQENA];

    // Compare value: a low-word write commits {shadow, data} and beats a periodic reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp <= '0;
        end else if (wr_en && sel == OFF_CMP_LO) begin
            cmp <= {cmp_shadow, wr_data};
        end else if (match && cfg[CFG_PERIODIC]) begin
            cmp <= cmp + {{HI_W{1'b0}}, period};
        end
    end

    // High-word write shadow and reload period are plain software registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_shadow <= '0;
            period     <= '0;
        end else if (wr_en) begin
            if (sel == OFF_CMP_HI) cmp_shadow <= wr_data[HI_W-1:0];
            if (sel == OFF_PERIOD) period     <= wr_data;
        end
    end

    // Configuration: a software write beats the one-shot self-disable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg <= '0;
        end else if (wr_en && sel == OFF_CFG) begin
            cfg <= wr_data[CFG_W-1:0];
        end else if (match && !cfg[CFG_PERIODIC]) begin
            cfg[CFG_ENA] <= 1'b0;
        end
    end

    // Pending flag: a match in the same cycle as a W1C keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (match) begin
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

    // Read view of this channel's window, selected by the low address bits
    always_comb begin
        rd_data = '0;
        case (sel)
            OFF_CMP_LO: rd_data = cmp[31:0];
            OFF_CMP_HI: rd_data = 32'(cmp[P_CNT_W-1:32]);
            OFF_CFG:    rd_data = 32'(cfg);
            OFF_PERIOD: rd_data = period;
            default:    rd_data = '0;
        endcase
    end

endmodule

// File: rtl/utim_nch.sv
// Multi-channel user timer: bus decode, prescaler, main counter, MCNT shadows,
// registered read port and the per-channel compare units.
module utim_nch
    import utim_pkg::*;
#(
    parameter int P_CH    = 4,
    parameter int P_CNT_W = 64,
    parameter int P_PSC_W = 16
) (
    input  logic            iCLOCK,
    input  logic            inRESET,
    input  logic            iREQ_VALID,
    output logic            oREQ_BUSY,
    input  logic            iREQ_RW,
    input  logic [5:0]      iREQ_ADDR,
    input  logic [31:0]     iREQ_DATA,
    output logic            oREQ_VALID,
    output logic [31:0]     oREQ_DATA,
    output logic [P_CH-1:0] oIRQ_IRQ
);

    localparam int HI_W = P_CNT_W - 32;

    logic               started;
    logic               busy;
    logic               rvalid;
    logic [31:0]        rdata;
    logic [31:0]        rd_mux;
    logic               ena;
    logic [P_CNT_W-1:0] count;
    logic [HI_W-1:0]    rd_shadow;
    logic [HI_W-1:0]    wr_shadow;
    logic [P_PSC_W-1:0] psc;
    logic [P_PSC_W-1:0] psc_cnt;
    logic               accept;
    logic               wr;
    logic               rd;
    logic               tick;
    logic               wr_mcfg;
    logic               wr_mcnt_lo;
    logic               wr_mcnt_hi;
    logic               wr_psc;
    logic               wr_irqstat;
    logic [P_CH-1:0]    ch_hit;
    logic [P_CH-1:0]    pending;
    logic [P_CH-1:0]    irq;
    logic [31:0]        ch_rdata [P_CH];

    assign accept     = iREQ_VALID & ~busy;
    assign wr         = accept & iREQ_RW;
    assign rd         = accept & ~iREQ_RW;
    assign wr_mcfg    = wr & (iREQ_ADDR == ADDR_MCFG);
    assign wr_mcnt_lo = wr & (iREQ_ADDR == ADDR_MCNT_LO);
    assign wr_mcnt_hi = wr & (iREQ_ADDR == ADDR_MCNT_HI);
    assign wr_psc     = wr & (iREQ_ADDR == ADDR_PSC);
    assign wr_irqstat = wr & (iREQ_ADDR == ADDR_IRQSTAT);
    assign tick       = ena & (psc_cnt == psc);

    assign oREQ_BUSY  = busy;
    assign oREQ_VALID = rvalid;
    assign oREQ_DATA  = rdata;
    assign oIRQ_IRQ   = irq;

    generate
        for (genvar n = 0; n < P_CH; n++) begin : g_ch
            assign ch_hit[n] = ({iREQ_ADDR[5:2], 2'b00} == ch_base(n));

            utim_channel #(
                .P_CNT_W (P_CNT_W)
            ) u_channel (
                .clk     (iCLOCK),
                .rst_n   (inRESET),
                .tick    (tick),
                .count   (count),
                .wr_en   (wr & ch_hit[n]),
                .clr     (wr_irqstat & iREQ_DATA[n]),
                .off     (iREQ_ADDR[1:0]),
                .wr_data (iREQ_DATA),
                .rd_data (ch_rdata[n]),
                .pending (pending[n]),
                .irq     (irq[n])
            );
        end
    endgenerate

    // Busy is raised for exactly the one cycle that follows the first edge out of reset
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            started <= 1'b0;
            busy    <= 1'b0;
        end else begin
            started <= 1'b1;
            busy    <= ~started;
        end
    end

    // Global enable, prescaler reload value and MCNT high-word write shadow
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            ena       <= 1'b0;
            psc       <= '0;
            wr_shadow <= '0;
        end else begin
            if (wr_mcfg)    ena       <= iREQ_DATA[MCFG_ENA];
            if (wr_psc)     psc       <= iREQ_DATA[P_PSC_W-1:0];
            if (wr_mcnt_hi) wr_shadow <= iREQ_DATA[HI_W-1:0];
        end
    end

    // Prescaler: counts 0..PSC while enabled; a count or PSC write restarts it
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            psc_cnt <= '0;
        end else if (wr_mcnt_lo || wr_psc || tick) begin
            psc_cnt <= '0;
        end else if (ena) begin
            psc_cnt <= psc_cnt + P_PSC_W'(1);
        end
    end

    // Main counter: a low-word write commits {shadow, data} and beats a tick
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            count <= '0;
        end else if (wr_mcnt_lo) begin
            count <= {wr_shadow, iREQ_DATA};
        end else if (tick) begin
            count <= count + P_CNT_W'(1);
        end
    end

    // Combinational read selection from the current register values
    always_comb begin
        rd_mux = '0;
        for (int n = 0; n < P_CH; n++) begin
            if (ch_hit[n]) rd_mux = ch_rdata[n];
        end
        case (iREQ_ADDR)
            ADDR_MCFG:    rd_mux = 32'(ena);
            ADDR_MCNT_LO: rd_mux = count[31:0];
            ADDR_MCNT_HI: rd_mux = 32'(rd_shadow);
            ADDR_PSC:     rd_mux = 32'(psc);
            ADDR_IRQSTAT: rd_mux = 32'(pending);
            default:      ;
        endcase
    end

    // Registered read return; a low-word count read also freezes the high word
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rvalid    <= 1'b0;
            rdata     <= '0;
            rd_shadow <= '0;
        end else begin
            rvalid <= rd;
            if (rd) rdata <= rd_mux;
            if (rd && iREQ_ADDR == ADDR_MCNT_LO) rd_shadow <= count[P_CNT_W-1:32];
        end
    end

endmodule

// File: tb/tb_utim_nch.sv
// Self-checking bench for utim_nch: directed scenarios plus randomized bus
// traffic compared against a transaction-level reference model.
module tb_utim_nch;

    localparam int P_CH = 4;

    logic            iCLOCK;
    logic            inRESET;
    logic            iREQ_VALID;
    logic            oREQ_BUSY;
    logic            iREQ_RW;
    logic [5:0]      iREQ_ADDR;
    logic [31:0]     iREQ_DATA;
    logic            oREQ_VALID;
    logic [31:0]     oREQ_DATA;
    logic [P_CH-1:0] oIRQ_IRQ;

    int checks = 0;
    int errors = 0;

    utim_nch #(
        .P_CH    (P_CH),
        .P_CNT_W (64),
        .P_PSC_W (16)
    ) dut (
        .iCLOCK     (iCLOCK),
        .inRESET    (inRESET),
        .iREQ_VALID (iREQ_VALID),
        .oREQ_BUSY  (oREQ_BUSY),
        .iREQ_RW    (iREQ_RW),
        .iREQ_ADDR  (iREQ_ADDR),
        .iREQ_DATA  (iREQ_DATA),
        .oREQ_VALID (oREQ_VALID),
        .oREQ_DATA  (oREQ_DATA),
        .oIRQ_IRQ   (oIRQ_IRQ)
    );

    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    // Reference model state, in software-visible terms
    logic            m_ena;
    logic            m_busy;
    logic            m_rvalid;
    logic [63:0]     m_count;
    logic [31:0]     m_pcnt;
    logic [31:0]     m_psc;
    logic [31:0]     m_rshadow;
    logic [31:0]     m_mwsh;
    logic [31:0]     m_rdata;
    int              m_edges;
    logic [63:0]     m_cmp    [P_CH];
    logic [31:0]     m_cmpsh  [P_CH];
    logic [31:0]     m_period [P_CH];
    logic [3:0]      m_cfg    [P_CH];
    logic [P_CH-1:0] m_pend;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_ena = 0; m_busy = 0; m_rvalid = 0; m_count = 0; m_pcnt = 0; m_psc = 0;
        m_rshadow = 0; m_mwsh = 0; m_rdata = 0; m_edges = 0; m_pend = 0;
        for (int n = 0; n < P_CH; n++) begin
            m_cmp[n] = 0; m_cmpsh[n] = 0; m_period[n] = 0; m_cfg[n] = 0;
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [5:0] a);
        int ai;
        ai = int'(a);
        if (ai == 0) return {31'b0, m_ena};
        if (ai == 1) return m_count[31:0];
        if (ai == 2) return m_rshadow;
        if (ai == 3) return m_psc;
        if (ai == 4) return {28'b0, m_pend};
        if (ai >= 8 && ai < 8 + 4 * P_CH) begin
            case (ai % 4)
                0: return m_cmp[(ai - 8) / 4][31:0];
                1: return m_cmp[(ai - 8) / 4][63:32];
                2: return {28'b0, m_cfg[(ai - 8) / 4]};
                default: return m_period[(ai - 8) / 4];
            endcase
        end
        return 32'h0;
    endfunction

    function automatic logic [P_CH-1:0] modelIrq();
        logic [P_CH-1:0] r;
        for (int n = 0; n < P_CH; n++) r[n] = m_pend[n] & m_cfg[n][1];
        return r;
    endfunction

    // Advance the model by one clock edge carrying the given request
    task automatic modelStep(input logic v, input logic rw, input logic [5:0] a, input logic [31:0] d);
        logic            acc;
        logic            tick;
        logic [P_CH-1:0] hit;
        logic [63:0]     n_count;
        logic [31:0]     n_pcnt;
        logic [P_CH-1:0] n_pend;
        int              ai;
        int              ch;
        acc = v && !m_busy;
        ai  = int'(a);
        m_rvalid = 0;
        if (acc && !rw) begin
            m_rdata  = modelRead(a);
            m_rvalid = 1;
            if (ai == 1) m_rshadow = m_count[63:32];
        end
        tick    = m_ena && (m_pcnt == m_psc);
        n_count = tick ? m_count + 64'd1 : m_count;
        n_pcnt  = !m_ena ? m_pcnt : (tick ? 32'd0 : m_pcnt + 32'd1);
        n_pend  = m_pend;
        for (int n = 0; n < P_CH; n++) begin
            hit[n] = tick && m_cfg[n][0] &&
                     (m_cfg[n][2] ? (m_count == m_cmp[n]) : (m_count[31:0] == m_cmp[n][31:0]));
            if (hit[n]) begin
                n_pend[n] = 1;
                if (m_cfg[n][3]) m_cmp[n] = m_cmp[n] + {32'b0, m_period[n]};
                else m_cfg[n][0] = 0;
            end
        end
        if (acc && rw) begin
            if (ai == 0) m_ena = d[0];
            if (ai == 1) begin n_count = {m_mwsh, d}; n_pcnt = 0; end
            if (ai == 2) m_mwsh = d;
            if (ai == 3) begin m_psc = d & 32'hFFFF; n_pcnt = 0; end
            if (ai == 4) n_pend = (m_pend & ~d[P_CH-1:0]) | hit;
            if (ai >= 8 && ai < 8 + 4 * P_CH) begin
                ch = (ai - 8) / 4;
                case (ai % 4)
                    0: m_cmp[ch] = {m_cmpsh[ch], d};
                    1: m_cmpsh[ch] = d;
                    2: m_cfg[ch] = d[3:0];
                    default: m_period[ch] = d;
                endcase
            end
        end
        m_count = n_count;
        m_pcnt  = n_pcnt;
        m_pend  = n_pend;
        m_edges++;
        m_busy  = (m_edges == 1);
    endtask

    // Drive one cycle at a falling edge, step the model at the rising edge, compare just after
    task automatic applyStimulus(input logic v, input logic rw, input logic [5:0] a, input logic [31:0] d);
        iREQ_VALID = v;
        iREQ_RW    = rw;
        iREQ_ADDR  = a;
        iREQ_DATA  = d;
        @(posedge iCLOCK);
        modelStep(v, rw, a, d);
        #1;
        checkOutput("busy", 64'(oREQ_BUSY), 64'(m_busy));
        checkOutput("rvalid", 64'(oREQ_VALID), 64'(m_rvalid));
        checkOutput("rdata", 64'(oREQ_DATA), 64'(m_rdata));
        checkOutput("irq", 64'(oIRQ_IRQ), 64'(modelIrq()));
        @(negedge iCLOCK);
    endtask

    task automatic writeReg(input logic [5:0] a, input logic [31:0] d);
        applyStimulus(1, 1, a, d);
    endtask

    task automatic readReg(input logic [5:0] a, output logic [31:0] d);
        applyStimulus(1, 0, a, 32'h0);
        d = oREQ_DATA;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 6'h0, 32'h0);
    endtask

    // Assert reset partway through the current cycle, check outputs drop at once, release on a falling edge
    task automatic doReset();
        #2 inRESET = 0;
        #1;
        checkOutput("rst_busy", 64'(oREQ_BUSY), 64'h0);
        checkOutput("rst_rvalid", 64'(oREQ_VALID), 64'h0);
        checkOutput("rst_rdata", 64'(oREQ_DATA), 64'h0);
        checkOutput("rst_irq", 64'(oIRQ_IRQ), 64'h0);
        modelReset();
        iREQ_VALID = 0;
        repeat (2) @(negedge iCLOCK);
        inRESET = 1;
    endtask

    logic [31:0] rv;
    logic [31:0] rd_lo;
    logic [31:0] rd_hi;
    int          rise [4];
    int          nrise;
    logic        prev_irq;
    logic        cur_irq;
    int          busy_cnt;
    int          valid_cnt;
    logic [5:0]  ra;
    logic [31:0] rdat;
    int          ri;

    initial begin
        inRESET = 0; iREQ_VALID = 0; iREQ_RW = 0; iREQ_ADDR = 0; iREQ_DATA = 0;
        @(negedge iCLOCK);
        doReset();
        idle(2);

        // One-shot on channel 0 at count 10
        writeReg(6'h03, 32'd0);
        writeReg(6'h09, 32'd0);
        writeReg(6'h08, 32'd10);
        writeReg(6'h0A, 32'h3);
        writeReg(6'h00, 32'h1);
        idle(15);
        checkOutput("t1_irq0_on", 64'(oIRQ_IRQ[0]), 64'h1);
        readReg(6'h0A, rv);
        checkOutput("t1_cfg0", 64'(rv), 64'h2);
        readReg(6'h04, rv);
        checkOutput("t1_stat", 64'(rv), 64'h1);
        writeReg(6'h04, 32'h1);
        checkOutput("t1_irq0_off", 64'(oIRQ_IRQ[0]), 64'h0);

        // Periodic channel 1 with prescaler 3: pending every 32 cycles
        doReset();
        idle(2);
        writeReg(6'h03, 32'd3);
        writeReg(6'h0D, 32'd0);
        writeReg(6'h0C, 32'd8);
        writeReg(6'h0F, 32'd8);
        writeReg(6'h0E, 32'hB);
        writeReg(6'h00, 32'h1);
        nrise = 0; prev_irq = 0;
        for (int i = 0; i < 4; i++) rise[i] = 0;
        for (int c = 0; c < 120; c++) begin
            cur_irq = oIRQ_IRQ[1];
            if (cur_irq && !prev_irq) begin
                if (nrise < 4) rise[nrise] = c;
                nrise++;
                writeReg(6'h04, 32'h2);
            end else begin
                idle(1);
            end
            prev_irq = cur_irq;
        end
        checkOutput("t2_rises", 64'(nrise >= 3), 64'h1);
        checkOutput("t2_gap1", 64'(rise[1] - rise[0]), 64'd32);
        checkOutput("t2_gap2", 64'(rise[2] - rise[1]), 64'd32);

        // Atomic count read across a low-word carry
        doReset();
        idle(2);
        writeReg(6'h02, 32'h0);
        writeReg(6'h01, 32'hFFFF_FFFE);
        writeReg(6'h03, 32'd0);
        writeReg(6'h00, 32'h1);
        readReg(6'h01, rd_lo);
        readReg(6'h02, rd_hi);
        checkOutput("t3_lo", 64'(rd_lo), 64'hFFFF_FFFE);
        checkOutput("t3_hi", 64'(rd_hi), 64'h0);
        readReg(6'h01, rd_lo);
        readReg(6'h02, rd_hi);
        idle(2);

        // 32-bit versus 64-bit compare on channel 2
        for (int m = 0; m < 2; m++) begin
            doReset();
            idle(2);
            writeReg(6'h03, 32'd0);
            writeReg(6'h11, 32'd5);
            writeReg(6'h10, 32'h20);
            writeReg(6'h12, (m == 0) ? 32'h3 : 32'h7);
            writeReg(6'h00, 32'h1);
            idle(40);
            checkOutput((m == 0) ? "t4_mode32" : "t4_mode64", 64'(oIRQ_IRQ[2]), (m == 0) ? 64'h1 : 64'h0);
        end

        // W1C on the very edge of a channel 3 match
        doReset();
        idle(2);
        writeReg(6'h03, 32'd0);
        writeReg(6'h15, 32'd0);
        writeReg(6'h14, 32'd6);
        writeReg(6'h16, 32'h7);
        writeReg(6'h00, 32'h1);
        idle(6);
        writeReg(6'h04, 32'h8);
        checkOutput("t5_w1c_set_wins", 64'(oIRQ_IRQ[3]), 64'h1);

        // Full-width wrap to zero then match at CMP = 0
        doReset();
        idle(2);
        writeReg(6'h02, 32'hFFFF_FFFF);
        writeReg(6'h01, 32'hFFFF_FFFF);
        writeReg(6'h15, 32'd0);
        writeReg(6'h14, 32'd0);
        writeReg(6'h16, 32'h7);
        writeReg(6'h00, 32'h1);
        idle(3);
        checkOutput("t5_wrap", 64'(oIRQ_IRQ[3]), 64'h1);

        // Reset while a read is being presented and an IRQ is active
        iREQ_VALID = 1; iREQ_RW = 0; iREQ_ADDR = 6'h01; iREQ_DATA = 0;
        doReset();
        busy_cnt = 0; valid_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            idle(1);
            if (oREQ_BUSY) busy_cnt++;
            if (oREQ_VALID) valid_cnt++;
        end
        checkOutput("t6_busy_cycles", 64'(busy_cnt), 64'd1);
        checkOutput("t6_no_rvalid", 64'(valid_cnt), 64'd0);

        // Randomized traffic against the model
        idle(1);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                doReset();
                idle(2);
            end
            ri = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 8 + 4 * P_CH - 1));
            ra = 6'(ri);
            rdat = $urandom;
            if (ri == 0) rdat = {31'b0, ($urandom_range(0, 5) != 0)};
            if (ri == 2) rdat = ($urandom_range(0, 1) == 1) ? 32'h0 : (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom);
            if (ri == 3) rdat = $urandom_range(0, 3);
            if (ri >= 8 && ri < 8 + 4 * P_CH) begin
                case (ri % 4)
                    0: rdat = m_count[31:0] + $urandom_range(0, 40);
                    1: rdat = ($urandom_range(0, 1) == 1) ? m_count[63:32] : $urandom;
                    2: rdat = $urandom_range(0, 15);
                    default: rdat = $urandom_range(1, 30);
                endcase
            end
            applyStimulus(($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1, ra, rdat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
